dpram_wr_sequencer: RTL and testbench
=====================================

Name: dpram_wr_sequencer

Overview:
- Write-side front end for the clk1 domain of the dual-port CDC RAM.
- Accepts a valid/ready byte stream and writes it as a frame into consecutive RAM addresses, starting at a programmable base address.
- Paces each write so the RAM's level-based request crosses into clk2 and returns to idle before the next write: wr_en is held for HOLD_CYC cycles, then kept low for GAP_CYC cycles.
- Reports frame completion, frame length and overflow.

Parameters:
- DW, 8: data width; matches the RAM word width.
- AW, 10: address width; the RAM depth is 2**AW.
- HOLD_CYC, 2: cycles wr_en stays high per byte; must be at least 1.
- GAP_CYC, 4: low cycles after each write; must be at least 3, which covers the 2-flop sync plus the ack release.

Ports:
- clk1  in  1  write-domain clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; arms a new frame.
- base_addr  in  AW  first write address; sampled on start.
- s_valid  in  1  input byte valid.
- s_ready  out  1  block can accept a byte this cycle.
- s_data  in  DW  input byte.
- s_last  in  1  marks the final byte of the frame; qualified by s_valid.
- wr_en  out  1  RAM write enable / request.
- wr_addr  out  AW  RAM write address.
- wr_data  out  DW  RAM write data.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse at end of frame.
- frame_len  out  AW+1  bytes written in the last frame; valid from frame_done until the next start.
- frame_ovf  out  1  last frame hit 2**AW bytes without s_last; sticky until next start.

Behaviour:
- Reset (asynchronous, active-low) forces all outputs to 0 immediately: wr_en, s_ready, busy, frame_done, frame_ovf, frame_len, wr_addr, wr_data. State goes to IDLE, the pointer to 0 and the count to 0.
- Reset mid-frame abandons the frame: no frame_done is produced, and bytes already written stay in the RAM.
- States:
  - IDLE: s_ready=0. On start: ptr<=base_addr, cnt<=0, frame_ovf<=0, go to ACCEPT.
  - ACCEPT: s_ready=1. On s_valid at the edge: latch s_data and s_last, timer<=HOLD_CYC, go to WRITE.
  - WRITE: wr_en=1, wr_addr=ptr, wr_data=latched byte, all registered. The timer decrements each cycle. When it expires: timer<=GAP_CYC, go to GAP.
  - GAP: wr_en=0, and wr_addr/wr_data hold their values. When the timer expires: ptr<=ptr+1 (mod 2**AW), cnt<=cnt+1, then:
    - if the latched last flag is set: go to DONE;
    - else if cnt+1 equals 2**AW: frame_ovf<=1, go to DONE;
    - else go to ACCEPT.
  - DONE: frame_done=1 for exactly one cycle, frame_len<=cnt, go to IDLE.
- Timing: a handshake at edge N drives wr_en high during cycles N+1 .. N+HOLD_CYC. Per-byte period is HOLD_CYC+GAP_CYC+1 cycles (7 at defaults).
- start while busy is ignored, including the DONE cycle.
- s_valid in IDLE, WRITE or GAP is not accepted (s_ready=0). The source must hold the byte until it is accepted.
- s_last is ignored unless s_valid is high in ACCEPT.
- Address wrap: ptr at 2**AW-1 increments to 0. Wrapping is legal and does not by itself set frame_ovf.
- Overflow: the 2**AW-th byte is written, then the frame ends with frame_ovf=1 and frame_len=2**AW. Any further stream bytes stay un-accepted until the next start.
- s_ready is a registered state decode. There is no combinational path from s_valid to s_ready.
- A start coincident with reset deassertion is not captured.

Decomposition:
- Shared package dpram_pkg holds:
  - state enum: IDLE, ACCEPT, WRITE, GAP, DONE;
  - localparams DW_DEF=8 and AW_DEF=10;
  - SYNC_STAGES=2 and MIN_GAP=SYNC_STAGES+1, used for an elaboration check on GAP_CYC.
- One sub-module, dpram_pace_timer: a loadable down-counter with a load value and an expire flag, used for both the HOLD and GAP phases.
- Everything else stays in the top module.

Test Plan:
- Reset, start, base_addr=0x010, 3 bytes 0xA1,0xB2,0xC3 (last on 0xC3) -> writes at 0x010/0x011/0x012, wr_en high 2 cycles each with 4 low between; frame_done pulse, frame_len=3, frame_ovf=0.
- base_addr=0x3FE, 4 bytes -> addresses 0x3FE,0x3FF,0x000,0x001; frame_ovf=0, frame_len=4.
- 1024 bytes with no s_last from base 0 -> the 1024th write lands at 0x3FF; frame_done with frame_len=1024, frame_ovf=1; byte 1025 is held with s_ready=0 until the next start.
- start pulsed during WRITE with base_addr=0x200 -> ignored; the current frame continues at the original ptr.
- s_valid held high continuously -> bytes accepted exactly 7 cycles apart; each s_data is captured only on an s_ready edge.
- rst_n pulled low during the 2nd cycle of WRITE -> wr_en falls without waiting for a clock edge, busy=0, no frame_done; after release, start with base 0x005 writes from 0x005.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared definitions for the clk1-side write sequencer of the dual-port CDC RAM.
package dpram_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    WRITE  = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam int DW_DEF      = 8;
  localparam int AW_DEF      = 10;
  // The RAM's request crosses a 2-flop synchronizer and the ack must release
  // before the next request, so the low phase needs one extra cycle.
  localparam int SYNC_STAGES = 2;
  localparam int MIN_GAP     = SYNC_STAGES + 1;

  // Bits needed by the pace timer to hold the larger of the two phase lengths.
  function automatic int timer_width(input int hold_cyc, input int gap_cyc);
    int tmax;
    tmax = (hold_cyc > gap_cyc) ? hold_cyc : gap_cyc;
    return $clog2(tmax + 1);
  endfunction

endpackage

// File: rtl/dpram_pace_timer.sv
// Loadable down-counter pacing the HOLD and GAP phases of each RAM write.
// expired_o is high during the last cycle of a loaded phase, so a load of N
// keeps the caller in its phase for exactly N cycles.
module dpram_pace_timer #(
  parameter int TW = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  output logic          expired_o
);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  // Next count: a load wins, otherwise count down and rest at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != {TW{1'b0}}) begin
      count_d = count_q - TW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= {TW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == TW'(1));

endmodule

// File: rtl/dpram_wr_sequencer.sv
// clk1-side write front end: turns a valid/ready byte stream into paced,
// level-held RAM write requests at consecutive addresses from a base, and
// reports frame length, completion and overflow.
module dpram_wr_sequencer
  import dpram_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int HOLD_CYC = 2,
  parameter int GAP_CYC  = 4
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          frame_done,
  output logic [AW:0]   frame_len,
  output logic          frame_ovf
);

  localparam int            TW       = timer_width(HOLD_CYC, GAP_CYC);
  localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYC);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYC);
  localparam logic [AW:0]   CNT_FULL = {1'b1, {AW{1'b0}}};

  if (GAP_CYC < MIN_GAP) begin : g_gap_check
    $error("GAP_CYC is too short for the request to cross and release");
  end
  if (HOLD_CYC < 1) begin : g_hold_check
    $error("HOLD_CYC must be at least 1");
  end

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   cnt_inc_s;
  logic          last_q, last_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW:0]   len_q, len_d;
  logic          ovf_q, ovf_d;
  // Goes high on the first clock after reset release; a start on that very
  // edge is therefore not captured.
  logic          armed_q;
  logic          s_ready_q, wr_en_q, busy_q, done_q;
  logic          tmr_load_s;
  logic [TW-1:0] tmr_val_s;
  logic          tmr_exp_s;

  assign cnt_inc_s = cnt_q + (AW + 1)'(1);

  dpram_pace_timer #(
    .TW(TW)
  ) u_pace_timer (
    .clk_i      (clk1),
    .rst_ni     (rst_n),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .expired_o  (tmr_exp_s)
  );

  // Next-state and datapath decisions for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    addr_d     = addr_q;
    data_d     = data_q;
    len_d      = len_q;
    ovf_d      = ovf_q;
    tmr_load_s = 1'b0;
    tmr_val_s  = {TW{1'b0}};
    case (state_q)
      IDLE: begin
        if (start && armed_q) begin
          state_d = ACCEPT;
          ptr_d   = base_addr;
          cnt_d   = {(AW + 1){1'b0}};
          ovf_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      ACCEPT: begin
        if (s_valid) begin
          state_d    = WRITE;
          addr_d     = ptr_q;
          data_d     = s_data;
          last_d     = s_last;
          tmr_load_s = 1'b1;
          tmr_val_s  = HOLD_LD;
        end else begin
          state_d = ACCEPT;
        end
      end
      WRITE: begin
        if (tmr_exp_s) begin
          state_d    = GAP;
          tmr_load_s = 1'b1;
          tmr_val_s  = GAP_LD;
        end else begin
          state_d = WRITE;
        end
      end
      GAP: begin
        if (tmr_exp_s) begin
          ptr_d = ptr_q + AW'(1);
          cnt_d = cnt_inc_s;
          if (last_q) begin
            state_d = DONE;
            len_d   = cnt_inc_s;
          end else if (cnt_inc_s == CNT_FULL) begin
            state_d = DONE;
            len_d   = cnt_inc_s;
            ovf_d   = 1'b1;
          end else begin
            state_d = ACCEPT;
          end
        end else begin
          state_d = GAP;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame pointer, byte count, latched byte and frame status registers.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= {AW{1'b0}};
      cnt_q   <= {(AW + 1){1'b0}};
      last_q  <= 1'b0;
      addr_q  <= {AW{1'b0}};
      data_q  <= {DW{1'b0}};
      len_q   <= {(AW + 1){1'b0}};
      ovf_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      armed_q <= 1'b1;
    end
  end

  // Registered decode of the upcoming state drives the handshake and RAM strobes.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      s_ready_q <= 1'b0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      s_ready_q <= (state_d == ACCEPT);
      wr_en_q   <= (state_d == WRITE);
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
    end
  end

  assign s_ready    = s_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign frame_len  = len_q;
  assign frame_ovf  = ovf_q;

endmodule

// File: tb/tb_dpram_wr_sequencer.sv
// Self-checking bench for dpram_wr_sequencer: randomized byte frames checked
// against a frame-level model (address = base + index mod depth, fixed
// per-byte period, frame length / overflow rules).
module tb_dpram_wr_sequencer;

  localparam int AW     = 10;
  localparam int DW     = 8;
  localparam int DEPTH  = 1024;
  localparam int HOLD   = 2;
  localparam int PERIOD = 7;

  logic          clk1 = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          frame_done;
  logic [AW:0]   frame_len;
  logic          frame_ovf;

  dpram_wr_sequencer #(
    .DW(DW), .AW(AW), .HOLD_CYC(HOLD), .GAP_CYC(4)
  ) dut (
    .clk1(clk1), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .frame_done(frame_done), .frame_len(frame_len), .frame_ovf(frame_ovf)
  );

  always #5 clk1 = ~clk1;

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;

  // Free-running cycle index used to time-stamp handshakes and write strobes.
  always @(posedge clk1) cyc <= cyc + 1;

  // Observed write episodes and frame completions.
  int   rise_c[$];
  int   w_addr[$];
  int   w_data[$];
  int   w_run[$];
  int   hs_c[$];
  int   cur_run = 0;
  logic prev_we = 1'b0;
  int   done_cnt = 0;
  int   done_len = 0;
  int   done_ovf = 0;

  // Reference model outputs.
  logic [7:0] tx_data[$];
  int   exp_addr[$];
  int   exp_data[$];
  int   exp_len;
  int   exp_ovf;

  // Monitor: record every wr_en episode (start cycle, addr, data, length) and frame_done pulses.
  always @(negedge clk1) begin
    if (wr_en === 1'b1) begin
      if (prev_we !== 1'b1) begin
        rise_c.push_back(cyc);
        w_addr.push_back(int'(wr_addr));
        w_data.push_back(int'(wr_data));
        cur_run <= 1;
      end else begin
        cur_run <= cur_run + 1;
      end
    end else if (prev_we === 1'b1) begin
      w_run.push_back(cur_run);
    end
    if (frame_done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_len <= int'(frame_len);
      done_ovf <= int'(frame_ovf);
    end
    prev_we <= wr_en;
  end

  // Frame model: byte i goes to (base+i) mod depth; without s_last the frame
  // stops after depth bytes and flags overflow.
  function automatic void model_frame(input int base, input int n, input bit has_last);
    int nw;
    exp_addr.delete();
    exp_data.delete();
    nw = (has_last || n < DEPTH) ? n : DEPTH;
    for (int i = 0; i < nw; i++) begin
      exp_addr.push_back((base + i) % DEPTH);
      exp_data.push_back(int'(tx_data[i]));
    end
    exp_len = nw;
    exp_ovf = (!has_last && nw == DEPTH) ? 1 : 0;
  endfunction

  task automatic clear_mon();
    rise_c.delete(); w_addr.delete(); w_data.delete(); w_run.delete(); hs_c.delete();
  endtask

  task automatic do_start(input logic [AW-1:0] b);
    @(negedge clk1);
    start = 1'b1; base_addr = b; s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk1);
    start = 1'b0;
  endtask

  // Source: offers bytes in order, holding each until s_ready; optional idle gaps.
  task automatic stream(input int n, input bit last_flag, input bit bubbles,
                        input int budget, output int acc);
    int  c;
    int  idx;
    int  k;
    bit  took;
    c = 0; idx = 0;
    while (idx < n && c < budget) begin
      if (bubbles) begin
        k = $urandom_range(0, 3);
        repeat (k) begin
          @(negedge clk1);
          s_valid = 1'b0; s_last = 1'($urandom_range(0, 1)); s_data = 8'($urandom);
          c++;
        end
      end
      took = 1'b0;
      while (!took && c < budget) begin
        @(negedge clk1);
        s_valid = 1'b1; s_data = tx_data[idx]; s_last = last_flag && (idx == n - 1);
        c++;
        if (s_ready === 1'b1) begin
          hs_c.push_back(cyc);
          took = 1'b1;
        end
      end
      if (took) idx++;
    end
    acc = idx;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk1);
      s_valid = 1'b0; s_last = 1'b0;
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
    repeat (2) @(negedge clk1);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk1);
    nvec++;
    if ({wr_en, s_ready, busy, frame_done, frame_ovf, frame_len, wr_addr, wr_data} !== '0) begin
      nfail++;
      $display("FAIL reset_outputs: got we=%b rdy=%b busy=%b done=%b ovf=%b len=%0h addr=%0h data=%0h expected all 0",
               wr_en, s_ready, busy, frame_done, frame_ovf, frame_len, wr_addr, wr_data);
    end
    // start coincident with the first edge after release must be ignored
    rst_n = 1'b1; start = 1'b1; base_addr = 10'h123;
    @(negedge clk1);
    start = 1'b0;
    nvec++;
    if (busy !== 1'b0 || s_ready !== 1'b0) begin
      nfail++;
      $display("FAIL start_at_release: got busy=%b ready=%b expected 0 0", busy, s_ready);
    end
    @(negedge clk1);
  endtask

  task automatic test_basic();
    int acc; bit ok; bit got; int d0;
    tx_data = '{8'hA1, 8'hB2, 8'hC3};
    clear_mon(); d0 = done_cnt;
    do_start(10'h010);
    nvec++;
    if (busy !== 1'b1 || s_ready !== 1'b1) begin
      nfail++; $display("FAIL basic_armed: got busy=%b ready=%b expected 1 1", busy, s_ready);
    end
    stream(3, 1'b1, 1'b0, 100, acc);
    // pulse start during the DONE cycle: must be ignored
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk1);
      s_valid = 1'b0; s_last = 1'b0;
      if (frame_done === 1'b1) begin got = 1'b1; start = 1'b1; base_addr = 10'h200; break; end
    end
    @(negedge clk1);
    start = 1'b0;
    nvec++;
    if (!got || busy !== 1'b0) begin
      nfail++; $display("FAIL basic_start_in_done: got done_seen=%b busy=%b expected 1 0", got, busy);
    end
    wait_idle(ok);
    model_frame(16, 3, 1'b1);
    nvec++;
    if (w_addr.size() != exp_addr.size() || w_run.size() != exp_addr.size() || hs_c.size() != exp_addr.size()) begin
      nfail++; $display("FAIL basic_nwrites: got %0d/%0d/%0d expected %0d", w_addr.size(), w_run.size(), hs_c.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < w_addr.size() && i < w_run.size() && i < hs_c.size(); i++) begin
      nvec++;
      if (w_addr[i] !== exp_addr[i] || w_data[i] !== exp_data[i] || w_run[i] !== HOLD || rise_c[i] !== hs_c[i] + 1) begin
        nfail++;
        $display("FAIL basic_write[%0d]: got addr=%0h data=%0h hold=%0d lag=%0d expected addr=%0h data=%0h hold=%0d lag=1",
                 i, w_addr[i], w_data[i], w_run[i], rise_c[i] - hs_c[i], exp_addr[i], exp_data[i], HOLD);
      end
      if (i > 0) begin
        nvec++;
        if (hs_c[i] - hs_c[i-1] != PERIOD) begin
          nfail++; $display("FAIL basic_period[%0d]: got %0d expected %0d", i, hs_c[i] - hs_c[i-1], PERIOD);
        end
      end
    end
    nvec++;
    if (done_cnt - d0 != 1 || done_len != exp_len || done_ovf != exp_ovf || int'(frame_len) != exp_len) begin
      nfail++;
      $display("FAIL basic_done: got pulses=%0d len=%0d ovf=%0d held_len=%0d expected 1 %0d %0d %0d",
               done_cnt - d0, done_len, done_ovf, frame_len, exp_len, exp_ovf, exp_len);
    end
  endtask

  task automatic test_wrap_random();
    int acc; bit ok; int d0; int base; int n; bit bub;
    for (int f = 0; f < 5; f++) begin
      base = (f == 0) ? 10'h3FE : $urandom_range(0, DEPTH - 1);
      n    = (f == 0) ? 4 : $urandom_range(1, 10);
      bub  = (f != 0);
      tx_data.delete();
      for (int i = 0; i < n; i++) tx_data.push_back(8'($urandom));
      clear_mon(); d0 = done_cnt;
      do_start(AW'(base));
      stream(n, 1'b1, bub, 400, acc);
      wait_idle(ok);
      model_frame(base, n, 1'b1);
      nvec++;
      if (!ok || acc != n || w_addr.size() != exp_addr.size() || w_run.size() != exp_addr.size()) begin
        nfail++;
        $display("FAIL frame%0d_count: got idle=%b acc=%0d writes=%0d expected 1 %0d %0d", f, ok, acc, w_addr.size(), n, exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < w_addr.size() && i < w_run.size() && i < hs_c.size(); i++) begin
        nvec++;
        if (w_addr[i] !== exp_addr[i] || w_data[i] !== exp_data[i] || w_run[i] !== HOLD || rise_c[i] !== hs_c[i] + 1) begin
          nfail++;
          $display("FAIL frame%0d_write[%0d]: got addr=%0h data=%0h hold=%0d expected addr=%0h data=%0h hold=%0d",
                   f, i, w_addr[i], w_data[i], w_run[i], exp_addr[i], exp_data[i], HOLD);
        end
        if (i > 0) begin
          nvec++;
          if (bub ? (hs_c[i] - hs_c[i-1] < PERIOD) : (hs_c[i] - hs_c[i-1] != PERIOD)) begin
            nfail++; $display("FAIL frame%0d_period[%0d]: got %0d expected %0d", f, i, hs_c[i] - hs_c[i-1], PERIOD);
          end
        end
      end
      nvec++;
      if (done_cnt - d0 != 1 || done_len != exp_len || done_ovf != exp_ovf) begin
        nfail++;
        $display("FAIL frame%0d_done: got pulses=%0d len=%0d ovf=%0d expected 1 %0d %0d", f, done_cnt - d0, done_len, done_ovf, exp_len, exp_ovf);
      end
    end
  endtask

  task automatic test_start_during_write();
    int acc; bit ok; int d0; int base;
    base = $urandom_range(0, 255);
    tx_data.delete();
    for (int i = 0; i < 4; i++) tx_data.push_back(8'($urandom));
    clear_mon(); d0 = done_cnt;
    do_start(AW'(base));
    fork
      stream(4, 1'b1, 1'b0, 100, acc);
      begin
        for (int i = 0; i < 50; i++) begin
          @(negedge clk1);
          if (wr_en === 1'b1) begin start = 1'b1; base_addr = 10'h200; break; end
        end
        @(negedge clk1);
        start = 1'b0;
      end
    join
    wait_idle(ok);
    model_frame(base, 4, 1'b1);
    nvec++;
    if (w_addr.size() != exp_addr.size()) begin
      nfail++; $display("FAIL sdw_nwrites: got %0d expected %0d", w_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < w_addr.size() && i < hs_c.size(); i++) begin
      nvec++;
      if (w_addr[i] !== exp_addr[i] || w_data[i] !== exp_data[i] || (i > 0 && hs_c[i] - hs_c[i-1] != PERIOD)) begin
        nfail++;
        $display("FAIL sdw_write[%0d]: got addr=%0h data=%0h expected addr=%0h data=%0h", i, w_addr[i], w_data[i], exp_addr[i], exp_data[i]);
      end
    end
    nvec++;
    if (done_cnt - d0 != 1 || done_len != 4 || done_ovf != 0) begin
      nfail++; $display("FAIL sdw_done: got pulses=%0d len=%0d ovf=%0d expected 1 4 0", done_cnt - d0, done_len, done_ovf);
    end
  endtask

  task automatic test_reset_mid_write();
    int acc; bit ok; bit got; int d0;
    clear_mon(); d0 = done_cnt;
    do_start(10'h155);
    @(negedge clk1);
    s_valid = 1'b1; s_data = 8'h5A; s_last = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk1);
      if (wr_en === 1'b1) begin got = 1'b1; break; end
    end
    s_valid = 1'b0;
    @(posedge clk1);
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if (!got || {wr_en, busy, s_ready, frame_done} !== 4'b0000 || wr_addr !== 10'h000) begin
      nfail++;
      $display("FAIL rst_async: got seen=%b we=%b busy=%b rdy=%b done=%b addr=%0h expected 1 0 0 0 0 0", got, wr_en, busy, s_ready, frame_done, wr_addr);
    end
    repeat (2) @(negedge clk1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk1);
    nvec++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      nfail++; $display("FAIL rst_no_done: got pulses=%0d busy=%b expected 0 0", done_cnt - d0, busy);
    end
    tx_data.delete();
    for (int i = 0; i < 2; i++) tx_data.push_back(8'($urandom));
    clear_mon(); d0 = done_cnt;
    do_start(10'h005);
    stream(2, 1'b1, 1'b0, 50, acc);
    wait_idle(ok);
    model_frame(5, 2, 1'b1);
    nvec++;
    if (w_addr.size() != 2 || w_addr[0] !== exp_addr[0] || w_addr[1] !== exp_addr[1]
        || w_data[0] !== exp_data[0] || w_data[1] !== exp_data[1] || done_len != exp_len || done_cnt - d0 != 1) begin
      nfail++;
      $display("FAIL rst_restart: got writes=%0d len=%0d pulses=%0d expected 2 writes from 005, len %0d", w_addr.size(), done_len, done_cnt - d0, exp_len);
    end
  endtask

  task automatic test_overflow();
    int acc; bit ok; int d0;
    tx_data.delete();
    for (int i = 0; i < DEPTH + 1; i++) tx_data.push_back(8'($urandom));
    clear_mon(); d0 = done_cnt;
    do_start(10'h000);
    stream(DEPTH + 1, 1'b0, 1'b0, DEPTH * PERIOD + 40, acc);
    // byte 1025 is still being offered here
    model_frame(0, DEPTH + 1, 1'b0);
    nvec++;
    if (acc != DEPTH || s_ready !== 1'b0 || busy !== 1'b0) begin
      nfail++; $display("FAIL ovf_held: got acc=%0d ready=%b busy=%b expected %0d 0 0", acc, s_ready, busy, DEPTH);
    end
    nvec++;
    if (frame_ovf !== 1'b1 || int'(frame_len) != exp_len || done_cnt - d0 != 1 || done_len != exp_len || done_ovf != exp_ovf) begin
      nfail++;
      $display("FAIL ovf_status: got ovf=%b len=%0d pulses=%0d expected 1 %0d 1", frame_ovf, frame_len, done_cnt - d0, exp_len);
    end
    nvec++;
    if (w_addr.size() != DEPTH || w_addr[w_addr.size() - 1] !== 10'h3FF) begin
      nfail++; $display("FAIL ovf_last_addr: got writes=%0d expected %0d ending at 3ff", w_addr.size(), DEPTH);
    end
    for (int i = 0; i < exp_addr.size() && i < w_addr.size() && i < hs_c.size(); i++) begin
      nvec++;
      if (w_addr[i] !== exp_addr[i] || w_data[i] !== exp_data[i] || (i > 0 && hs_c[i] - hs_c[i-1] != PERIOD)) begin
        nfail++;
        $display("FAIL ovf_write[%0d]: got addr=%0h data=%0h expected addr=%0h data=%0h", i, w_addr[i], w_data[i], exp_addr[i], exp_data[i]);
      end
    end
    // new frame picks up the held byte; overflow flag clears on start
    @(posedge clk1);
    #1 clear_mon(); d0 = done_cnt;
    @(negedge clk1);
    start = 1'b1; base_addr = 10'h0AB;
    @(negedge clk1);
    start = 1'b0; s_last = 1'b1;
    nvec++;
    if (frame_ovf !== 1'b0 || s_ready !== 1'b1) begin
      nfail++; $display("FAIL ovf_clear: got ovf=%b ready=%b expected 0 1", frame_ovf, s_ready);
    end
    wait_idle(ok);
    nvec++;
    if (w_addr.size() != 1 || w_addr[0] !== 32'h0AB || w_data[0] !== int'(tx_data[DEPTH]) || done_len != 1 || done_ovf != 0) begin
      nfail++;
      $display("FAIL ovf_next_frame: got writes=%0d len=%0d ovf=%0d expected 1 write at 0ab, len 1, ovf 0", w_addr.size(), done_len, done_ovf);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    test_reset();
    test_basic();
    test_wrap_random();
    test_start_during_write();
    test_reset_mid_write();
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
